controller_sequencer: RTL and testbench

- Control-side counterpart of the bus multiplexer: produces the one-hot bus-driver enables (a/pc/ram/ireg/alu) that the multiplexer consumes, plus all register load strobes.
- Runs the SAP-1 fetch/execute cycle as a 6-state ring counter (T1..T6) and decodes the 4-bit opcode from the instruction register.
- Sits between the instruction register and every datapath block.

---
 rtl/controller_sequencer_if.sv | 33 +++
 rtl/controller_sequencer.sv | 150 +++++++++++++++
 tb/tb_controller_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/controller_sequencer_if.sv
// Control bundle between the SAP-1 sequencer and the datapath: opcode in,
// bus-driver enables, load strobes and status out.
interface controller_sequencer_if;
  logic [3:0] opcode;
  logic       pc_data_en;
  logic       ram_data_en;
  logic       ireg_data_en;
  logic       a_data_en;
  logic       alu_data_en;
  logic       mar_load;
  logic       pc_inc;
  logic       ir_load;
  logic       a_load;
  logic       b_load;
  logic       out_load;
  logic       alu_sub;
  logic       halted;
  logic [5:0] tstate;

  modport master (
    input  opcode,
    output pc_data_en, ram_data_en, ireg_data_en, a_data_en, alu_data_en,
    output mar_load, pc_inc, ir_load, a_load, b_load, out_load, alu_sub,
    output halted, tstate
  );

  modport slave (
    output opcode,
    input  pc_data_en, ram_data_en, ireg_data_en, a_data_en, alu_data_en,
    input  mar_load, pc_inc, ir_load, a_load, b_load, out_load, alu_sub,
    input  halted, tstate
  );
endinterface

// File: rtl/controller_sequencer.sv
// SAP-1 controller/sequencer: six-state one-hot ring counter (T1..T6) with a
// halt flag, decoding the IR opcode into bus-driver enables and load strobes.
module controller_sequencer (
  input  logic                          clk,
  input  logic                          rst,
  controller_sequencer_if.master        bus
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  tstate_e tstate_q, tstate_d;
  logic    halted_q, halted_d;

  logic pc_data_en_s, ram_data_en_s, ireg_data_en_s, a_data_en_s, alu_data_en_s;
  logic mar_load_s, pc_inc_s, ir_load_s, a_load_s, b_load_s, out_load_s, alu_sub_s;

  // State register; reset wins over both advance and halt set.
  always_ff @(posedge clk) begin
    if (rst) begin
      tstate_q <= T1;
      halted_q <= 1'b0;
    end else begin
      tstate_q <= tstate_d;
      halted_q <= halted_d;
    end
  end

  // Next-state: ring advance, HLT freezes the ring at T4.
  always_comb begin
    tstate_d = tstate_q;
    halted_d = halted_q;
    if (halted_q) begin
      tstate_d = T4;
    end else begin
      case (tstate_q)
        T1: tstate_d = T2;
        T2: tstate_d = T3;
        T3: tstate_d = T4;
        T4: begin
          if (bus.opcode == OP_HLT) begin
            halted_d = 1'b1;
            tstate_d = T4;
          end else begin
            tstate_d = T5;
          end
        end
        T5: tstate_d = T6;
        T6: tstate_d = T1;
        default: tstate_d = T1;
      endcase
    end
  end

  // Control-word decode; everything is held low once halted.
  always_comb begin
    pc_data_en_s   = 1'b0;
    ram_data_en_s  = 1'b0;
    ireg_data_en_s = 1'b0;
    a_data_en_s    = 1'b0;
    alu_data_en_s  = 1'b0;
    mar_load_s     = 1'b0;
    pc_inc_s       = 1'b0;
    ir_load_s      = 1'b0;
    a_load_s       = 1'b0;
    b_load_s       = 1'b0;
    out_load_s     = 1'b0;
    alu_sub_s      = 1'b0;
    if (halted_q) begin
      pc_data_en_s = 1'b0;
    end else begin
      case (tstate_q)
        T1: begin
          pc_data_en_s = 1'b1;
          mar_load_s   = 1'b1;
        end
        T2: pc_inc_s = 1'b1;
        T3: begin
          ram_data_en_s = 1'b1;
          ir_load_s     = 1'b1;
        end
        T4: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ireg_data_en_s = 1'b1;
              mar_load_s     = 1'b1;
            end
            OP_OUT: begin
              a_data_en_s = 1'b1;
              out_load_s  = 1'b1;
            end
            default: a_data_en_s = 1'b0;
          endcase
        end
        T5: begin
          case (bus.opcode)
            OP_LDA: begin
              ram_data_en_s = 1'b1;
              a_load_s      = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_data_en_s = 1'b1;
              b_load_s      = 1'b1;
            end
            default: ram_data_en_s = 1'b0;
          endcase
        end
        T6: begin
          case (bus.opcode)
            OP_ADD, OP_SUB: begin
              alu_data_en_s = 1'b1;
              a_load_s      = 1'b1;
              alu_sub_s     = (bus.opcode == OP_SUB);
            end
            default: alu_data_en_s = 1'b0;
          endcase
        end
        default: pc_data_en_s = 1'b0;
      endcase
    end
  end

  assign bus.pc_data_en   = pc_data_en_s;
  assign bus.ram_data_en  = ram_data_en_s;
  assign bus.ireg_data_en = ireg_data_en_s;
  assign bus.a_data_en    = a_data_en_s;
  assign bus.alu_data_en  = alu_data_en_s;
  assign bus.mar_load     = mar_load_s;
  assign bus.pc_inc       = pc_inc_s;
  assign bus.ir_load      = ir_load_s;
  assign bus.a_load       = a_load_s;
  assign bus.b_load       = b_load_s;
  assign bus.out_load     = out_load_s;
  assign bus.alu_sub      = alu_sub_s;
  assign bus.halted       = halted_q;
  assign bus.tstate       = tstate_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer: directed vectors with literal
// expected control words, then a reference-modelled opcode stream.
module tb_controller_sequencer;

  logic clk;
  logic rst;
  controller_sequencer_if bus_if ();

  controller_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: {tstate[5:0], halted, pc, ram, ireg, a, alu, mar, inc, ir, a_ld, b_ld, out_ld, sub}
  localparam logic [18:0] X_SUB  = 19'h00001;
  localparam logic [18:0] X_OUT  = 19'h00002;
  localparam logic [18:0] X_BL   = 19'h00004;
  localparam logic [18:0] X_AL   = 19'h00008;
  localparam logic [18:0] X_IR   = 19'h00010;
  localparam logic [18:0] X_INC  = 19'h00020;
  localparam logic [18:0] X_MAR  = 19'h00040;
  localparam logic [18:0] X_ALU  = 19'h00080;
  localparam logic [18:0] X_A    = 19'h00100;
  localparam logic [18:0] X_IREG = 19'h00200;
  localparam logic [18:0] X_RAM  = 19'h00400;
  localparam logic [18:0] X_PC   = 19'h00800;
  localparam logic [18:0] X_HLT  = 19'h01000;
  localparam logic [18:0] T1 = 19'h02000;
  localparam logic [18:0] T2 = 19'h04000;
  localparam logic [18:0] T3 = 19'h08000;
  localparam logic [18:0] T4 = 19'h10000;
  localparam logic [18:0] T5 = 19'h20000;
  localparam logic [18:0] T6 = 19'h40000;

  logic [18:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;

  int   m_t;
  logic m_h;

  function automatic logic [18:0] model_exp(input int t, input logic h, input logic [3:0] op);
    logic [18:0] v;
    v = 19'd1 << (13 + t);
    if (h) return v | X_HLT;
    case (t)
      0: v = v | X_PC | X_MAR;
      1: v = v | X_INC;
      2: v = v | X_RAM | X_IR;
      3: begin
        if (op == 4'h0 || op == 4'h1 || op == 4'h2) v = v | X_IREG | X_MAR;
        else if (op == 4'hE) v = v | X_A | X_OUT;
      end
      4: begin
        if (op == 4'h0) v = v | X_RAM | X_AL;
        else if (op == 4'h1 || op == 4'h2) v = v | X_RAM | X_BL;
      end
      5: begin
        if (op == 4'h1) v = v | X_ALU | X_AL;
        else if (op == 4'h2) v = v | X_ALU | X_AL | X_SUB;
      end
      default: v = v;
    endcase
    return v;
  endfunction

  // One cycle: drive inputs, queue the expected word, advance the model.
  task automatic step(input string nm, input logic r, input logic [3:0] op, input logic [18:0] ev);
    rst = r;
    bus_if.opcode = op;
    exp_q.push_back(ev);
    name_q.push_back(nm);
    if (r) begin
      m_t = 0;
      m_h = 1'b0;
    end else if (!m_h) begin
      if (m_t == 3 && op == 4'hF) m_h = 1'b1;
      else m_t = (m_t == 5) ? 0 : m_t + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string nm, input logic [3:0] op);
    step({nm, "_t1"}, 1'b0, op, T1 | X_PC | X_MAR);
    step({nm, "_t2"}, 1'b0, op, T2 | X_INC);
    step({nm, "_t3"}, 1'b0, op, T3 | X_RAM | X_IR);
  endtask

  // Monitor: pop and compare on every falling edge, plus invariants.
  always @(negedge clk) begin
    logic [18:0] act;
    logic [4:0]  drv;
    if (mon_en) begin
      act = {bus_if.tstate, bus_if.halted, bus_if.pc_data_en, bus_if.ram_data_en,
             bus_if.ireg_data_en, bus_if.a_data_en, bus_if.alu_data_en, bus_if.mar_load,
             bus_if.pc_inc, bus_if.ir_load, bus_if.a_load, bus_if.b_load,
             bus_if.out_load, bus_if.alu_sub};
      drv = act[11:7];
      n_checks++;
      if (!$onehot(bus_if.tstate)) begin
        n_fail++;
        $display("FAIL tstate_onehot: got %b, required exactly one bit set", bus_if.tstate);
      end
      n_checks++;
      if (!$onehot0(drv)) begin
        n_fail++;
        $display("FAIL drivers_onehot0: got %b, required at most one bit set", drv);
      end
      if (exp_q.size() > 0) begin
        logic [18:0] ev;
        string nm;
        ev = exp_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if (act !== ev) begin
          n_fail++;
          $display("FAIL %s: got %05h, required %05h", nm, act, ev);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] op;
    logic [3:0] junk;
    rst = 1'b1;
    bus_if.opcode = 4'h0;
    m_t = 0;
    m_h = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // LDA free-run, then SUB, ADD, OUT
    fetch("lda", 4'h0);
    step("lda_t4", 1'b0, 4'h0, T4 | X_IREG | X_MAR);
    step("lda_t5", 1'b0, 4'h0, T5 | X_RAM | X_AL);
    step("lda_t6", 1'b0, 4'h0, T6);
    fetch("sub", 4'h2);
    step("sub_t4", 1'b0, 4'h2, T4 | X_IREG | X_MAR);
    step("sub_t5", 1'b0, 4'h2, T5 | X_RAM | X_BL);
    step("sub_t6", 1'b0, 4'h2, T6 | X_ALU | X_AL | X_SUB);
    fetch("add", 4'h1);
    step("add_t4", 1'b0, 4'h1, T4 | X_IREG | X_MAR);
    step("add_t5", 1'b0, 4'h1, T5 | X_RAM | X_BL);
    step("add_t6", 1'b0, 4'h1, T6 | X_ALU | X_AL);
    fetch("out", 4'hE);
    step("out_t4", 1'b0, 4'hE, T4 | X_A | X_OUT);
    step("out_t5", 1'b0, 4'hE, T5);
    step("out_t6", 1'b0, 4'hE, T6);

    // Reset during T5 of ADD aborts the instruction before its a_load
    fetch("addrst", 4'h1);
    step("addrst_t4", 1'b0, 4'h1, T4 | X_IREG | X_MAR);
    step("addrst_t5", 1'b1, 4'h1, T5 | X_RAM | X_BL);
    step("addrst_after", 1'b0, 4'h1, T1 | X_PC | X_MAR);
    step("addrst_t2", 1'b0, 4'h1, T2 | X_INC);
    step("addrst_t3", 1'b0, 4'h1, T3 | X_RAM | X_IR);
    step("lda2_t4", 1'b0, 4'h0, T4 | X_IREG | X_MAR);
    step("lda2_t5", 1'b0, 4'h0, T5 | X_RAM | X_AL);
    step("lda2_t6", 1'b0, 4'h0, T6);

    // HLT, stay halted with varying opcodes, then reset out
    fetch("hlt", 4'hF);
    step("hlt_t4", 1'b0, 4'hF, T4);
    for (int i = 0; i < 22; i++) begin
      step("halted_hold", 1'b0, 4'(i), T4 | X_HLT);
    end
    step("halted_rst", 1'b1, 4'h1, T4 | X_HLT);
    step("post_rst_t1", 1'b0, 4'h0, T1 | X_PC | X_MAR);
    step("post_rst_t2", 1'b0, 4'h0, T2 | X_INC);
    step("post_rst_t3", 1'b0, 4'h0, T3 | X_RAM | X_IR);
    step("post_rst_t4", 1'b0, 4'h0, T4 | X_IREG | X_MAR);
    step("post_rst_t5", 1'b0, 4'h0, T5 | X_RAM | X_AL);
    step("post_rst_t6", 1'b0, 4'h0, T6);

    // Modelled stream; fetch cycles carry junk opcodes (even HLT) that must be ignored
    for (int i = 0; i < 200; i++) begin
      if (i % 10 == 0) op = 4'h5;
      else if (i % 10 == 5) op = 4'h9;
      else op = 4'($urandom_range(0, 14));
      for (int t = 0; t < 6; t++) begin
        if (t < 3) begin
          junk = 4'($urandom_range(0, 15));
          step("rand_fetch", 1'b0, junk, model_exp(m_t, m_h, junk));
        end else begin
          step("rand_exec", 1'b0, op, model_exp(m_t, m_h, op));
        end
      end
    end

    mon_en = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
